// File: rtl/paint_write_queue_if.sv
// Pixel-write / memory-write bus between the board painter, the write queue
// and the video-memory port.
//
// Handshake: the painter presents {pix_address, pix_color} together with
// pix_print_enable; the queue captures one entry on each rising edge of
// pix_print_enable. On the memory side, mem_ready=1 means the port takes a write
// this cycle. mem_write is a single-cycle strobe qualifying mem_address and
// mem_color. frame_flushed is level-held until frame_done falls.
`ifndef MEMORY_SIZE_BITS
`define MEMORY_SIZE_BITS 16
`endif

interface paint_write_queue_if #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = `MEMORY_SIZE_BITS,
  parameter int COLOR_W = 3
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pix_address;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_print_enable;
  logic               frame_done;
  logic               mem_ready;
  logic [ADDR_W-1:0]  mem_address;
  logic [COLOR_W-1:0] mem_color;
  logic               mem_write;
  logic               frame_flushed;
  logic               overflow;
  logic [LVL_W-1:0]   level;
  logic               frame_state;  // debug view of the frame handshake FSM

  modport master (
    output pix_address, pix_color, pix_print_enable, frame_done, mem_ready,
    input  mem_address, mem_color, mem_write, frame_flushed, overflow, level,
    input  frame_state
  );

  modport slave (
    input  pix_address, pix_color, pix_print_enable, frame_done, mem_ready,
    output mem_address, mem_color, mem_write, frame_flushed, overflow, level,
    output frame_state
  );
endinterface

// File: rtl/paint_write_queue.sv
// Write queue between the board painter and the video-memory write port.
// Each painter enable episode becomes one queued entry; entries drain as
// single-cycle memory writes whenever the port is ready. A two-state FSM
// reports when the painter's frame is done and everything has been written.
`ifndef MEMORY_SIZE_BITS
`define MEMORY_SIZE_BITS 16
`endif

module paint_write_queue #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = `MEMORY_SIZE_BITS,
  parameter int COLOR_W = 3
) (
  input  logic               Clck,
  input  logic               Reset,
  paint_write_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + COLOR_W;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_FLUSHED = 1'b1
  } state_t;

  state_t             state;
  logic [ENT_W-1:0]   store [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LVL_W-1:0]   level;
  logic               pe_prev;
  logic               push;
  logic               pop;
  logic               accept;
  logic               mem_write_q;
  logic               flushed_q;
  logic               overflow_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [COLOR_W-1:0] color_q;

  // One push per enable episode, however long the painter holds enable.
  assign push   = bus.pix_print_enable & ~pe_prev;
  assign pop    = (level != '0) & bus.mem_ready;
  // A full queue still accepts when the same edge frees a slot.
  assign accept = push & ((level != FULL) | pop);

  // Edge detector, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      pe_prev    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      pe_prev <= bus.pix_print_enable;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (push && !accept) overflow_q <= 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge Clck) begin
    if (accept) store[wr_ptr] <= {bus.pix_address, bus.pix_color};
  end

  // Registered memory-side outputs: one strobe per popped entry.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      color_q     <= '0;
    end else if (pop) begin
      mem_write_q <= 1'b1;
      {addr_q, color_q} <= store[rd_ptr];
    end else begin
      mem_write_q <= 1'b0;
    end
  end

  // Frame handshake: flushed only once nothing is queued, arriving or in flight.
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      flushed_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.frame_done && (level == '0) && !push && !mem_write_q) begin
            state     <= ST_FLUSHED;
            flushed_q <= 1'b1;
          end
        end
        ST_FLUSHED: begin
          if (!bus.frame_done) begin
            state     <= ST_IDLE;
            flushed_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          flushed_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_address   = addr_q;
  assign bus.mem_color     = color_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.frame_flushed = flushed_q;
  assign bus.overflow      = overflow_q;
  assign bus.level         = level;
  assign bus.frame_state   = state;
endmodule

// File: tb/tb_paint_write_queue.sv
// Bench for paint_write_queue: directed scenarios plus a randomized run
// checked cycle by cycle against a queue-based reference model.
module tb_paint_write_queue;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 16;
  localparam int COLOR_W = 3;
  localparam int W       = ADDR_W + COLOR_W;

  logic Clck;
  logic Reset;
  int   n_cmp;
  int   n_fail;

  paint_write_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) bus ();

  paint_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) dut (
    .Clck  (Clck),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clck = 1'b0;
  always #5 Clck = ~Clck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // The queue holds pending pixels; outputs are what the memory side should see.
  logic [W-1:0]       exp_q[$];
  logic               m_pe_prev;
  logic               m_mw;
  logic [ADDR_W-1:0]  m_addr;
  logic [COLOR_W-1:0] m_color;
  logic               m_flushed;
  logic               m_overflow;

  always @(posedge Clck) begin : ref_model
    int           old_size;
    logic         old_mw;
    logic         push;
    logic         pop;
    logic [W-1:0] ent;
    if (!Reset) begin
      exp_q.delete();
      m_pe_prev  = 1'b0;
      m_mw       = 1'b0;
      m_addr     = '0;
      m_color    = '0;
      m_flushed  = 1'b0;
      m_overflow = 1'b0;
    end else begin
      old_size = exp_q.size();
      old_mw   = m_mw;
      push     = bus.pix_print_enable && !m_pe_prev;
      pop      = (old_size != 0) && bus.mem_ready;
      if (pop) begin
        ent     = exp_q.pop_front();
        m_addr  = ent[W-1:COLOR_W];
        m_color = ent[COLOR_W-1:0];
        m_mw    = 1'b1;
      end else begin
        m_mw = 1'b0;
      end
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({bus.pix_address, bus.pix_color});
        else m_overflow = 1'b1;
      end
      if (!m_flushed) begin
        if (bus.frame_done && old_size == 0 && !push && !old_mw) m_flushed = 1'b1;
      end else if (!bus.frame_done) begin
        m_flushed = 1'b0;
      end
      m_pe_prev = bus.pix_print_enable;
    end
  end

  // Passive log of every write the DUT issues.
  logic [W-1:0] obs_log[$];
  always @(posedge Clck) begin
    #1;
    if (bus.mem_write === 1'b1) obs_log.push_back({bus.mem_address, bus.mem_color});
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    Reset = 1'b0;
    repeat (cycles) @(negedge Clck);
    Reset = 1'b1;
  endtask

  // Enable held hi cycles then low lo cycles; the address is scrambled after
  // the first high cycle so only the push-cycle sample may be captured.
  task automatic send_pixel(input logic [ADDR_W-1:0] a, input logic [COLOR_W-1:0] c,
                            input int hi, input int lo);
    bus.pix_address      = a;
    bus.pix_color        = c;
    bus.pix_print_enable = 1'b1;
    @(negedge Clck);
    bus.pix_address = ADDR_W'($urandom);
    bus.pix_color   = COLOR_W'($urandom);
    repeat (hi - 1) @(negedge Clck);
    bus.pix_print_enable = 1'b0;
    repeat (lo) @(negedge Clck);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    bus.pix_print_enable = 1'b0;
    bus.frame_done       = 1'b0;
    bus.mem_ready        = 1'b0;
    bus.pix_address      = '0;
    bus.pix_color        = '0;
    do_reset(2);
    n_cmp++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.level); end
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b want 0", bus.mem_write); end
    n_cmp++; if (bus.mem_address !== 16'h0 || bus.mem_color !== 3'd0) begin
      n_fail++; $display("FAIL reset_mem_bus got %h/%0d want 0/0", bus.mem_address, bus.mem_color); end
    n_cmp++; if (bus.overflow !== 1'b0 || bus.frame_flushed !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got ovf=%b fl=%b want 0/0", bus.overflow, bus.frame_flushed); end
  endtask

  task automatic test_single_pixel;
    do_reset(2);
    bus.mem_ready = 1'b1;
    obs_log.delete();
    bus.pix_address = 16'h0123; bus.pix_color = 3'b001; bus.pix_print_enable = 1'b1;
    @(negedge Clck);  // after enqueue edge
    n_cmp++; if (bus.mem_write !== 1'b0 || bus.level !== 5'd1) begin
      n_fail++; $display("FAIL single_enqueue got mw=%b lvl=%0d want 0/1", bus.mem_write, bus.level); end
    @(negedge Clck);  // after output edge
    n_cmp++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 16'h0123 || bus.mem_color !== 3'b001) begin
      n_fail++; $display("FAIL single_write got mw=%b addr=%h col=%0d want 1/0123/1",
                         bus.mem_write, bus.mem_address, bus.mem_color); end
    bus.pix_print_enable = 1'b0;
    @(negedge Clck);
    n_cmp++; if (bus.mem_write !== 1'b0 || bus.level !== 5'd0) begin
      n_fail++; $display("FAIL single_after got mw=%b lvl=%0d want 0/0", bus.mem_write, bus.level); end
    repeat (4) @(negedge Clck);
    n_cmp++; if (obs_log.size() != 1) begin
      n_fail++; $display("FAIL single_count got %0d want 1", obs_log.size()); end
  endtask

  task automatic test_stall_order;
    logic [COLOR_W-1:0] cols[5];
    do_reset(2);
    bus.mem_ready = 1'b0;
    obs_log.delete();
    for (int i = 0; i < 5; i++) begin
      cols[i] = COLOR_W'($urandom);
      send_pixel(ADDR_W'(10 + i), cols[i], 2, 2);
    end
    n_cmp++; if (bus.level !== 5'd5 || obs_log.size() != 0) begin
      n_fail++; $display("FAIL stall_level got lvl=%0d writes=%0d want 5/0", bus.level, obs_log.size()); end
    bus.mem_ready = 1'b1;
    repeat (8) @(negedge Clck);
    n_cmp++; if (obs_log.size() != 5) begin
      n_fail++; $display("FAIL stall_count got %0d want 5", obs_log.size()); end
    for (int i = 0; i < 5 && i < obs_log.size(); i++) begin
      n_cmp++; if (obs_log[i] !== {ADDR_W'(10 + i), cols[i]}) begin
        n_fail++; $display("FAIL stall_order[%0d] got %h want %h", i, obs_log[i], {ADDR_W'(10 + i), cols[i]}); end
    end
  endtask

  task automatic test_overflow;
    do_reset(2);
    bus.mem_ready = 1'b0;
    obs_log.delete();
    for (int i = 0; i < DEPTH + 1; i++) send_pixel(ADDR_W'(100 + i), COLOR_W'(i), 1, 1);
    n_cmp++; if (bus.level !== 5'd16 || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_full got lvl=%0d ovf=%b want 16/1", bus.level, bus.overflow); end
    bus.mem_ready = 1'b1;
    repeat (20) @(negedge Clck);
    n_cmp++; if (obs_log.size() != DEPTH) begin
      n_fail++; $display("FAIL ovf_drain_count got %0d want %0d", obs_log.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < obs_log.size(); i++) begin
      n_cmp++; if (obs_log[i] !== {ADDR_W'(100 + i), COLOR_W'(i)}) begin
        n_fail++; $display("FAIL ovf_order[%0d] got %h want %h", i, obs_log[i], {ADDR_W'(100 + i), COLOR_W'(i)}); end
    end
    n_cmp++; if (bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
  endtask

  task automatic test_full_simultaneous;
    do_reset(2);
    bus.mem_ready = 1'b0;
    obs_log.delete();
    for (int i = 0; i < DEPTH; i++) send_pixel(ADDR_W'(200 + i), 3'd2, 1, 1);
    n_cmp++; if (bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_pre got lvl=%0d ovf=%b want 16/0", bus.level, bus.overflow); end
    bus.pix_address = 16'd300; bus.pix_color = 3'd5; bus.pix_print_enable = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge Clck);
    bus.pix_print_enable = 1'b0;
    n_cmp++; if (bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_simul got lvl=%0d ovf=%b want 16/0", bus.level, bus.overflow); end
    repeat (20) @(negedge Clck);
    n_cmp++; if (obs_log.size() != DEPTH + 1) begin
      n_fail++; $display("FAIL full_count got %0d want %0d", obs_log.size(), DEPTH + 1); end
    else begin
      n_cmp++; if (obs_log[DEPTH] !== {16'd300, 3'd5}) begin
        n_fail++; $display("FAIL full_last got %h want %h", obs_log[DEPTH], {16'd300, 3'd5}); end
    end
  endtask

  task automatic test_frame_flush;
    bit seen;
    do_reset(2);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pixel(ADDR_W'(40 + i), 3'd7, 2, 1);
    bus.frame_done = 1'b1;
    repeat (3) @(negedge Clck);
    n_cmp++; if (bus.frame_flushed !== 1'b0) begin
      n_fail++; $display("FAIL flush_pending got %b want 0", bus.frame_flushed); end
    bus.mem_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clck);
      n_cmp++; if (bus.frame_flushed !== m_flushed || bus.mem_write !== m_mw) begin
        n_fail++; $display("FAIL flush_cycle%0d got fl=%b mw=%b want %b/%b", i,
                           bus.frame_flushed, bus.mem_write, m_flushed, m_mw); end
      n_cmp++; if (bus.frame_flushed === 1'b1 && (bus.mem_write !== 1'b0 || bus.level !== 5'd0)) begin
        n_fail++; $display("FAIL flush_early got mw=%b lvl=%0d want 0/0", bus.mem_write, bus.level); end
      if (bus.frame_flushed === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin
      n_fail++; $display("FAIL flush_timeout got never want 1 within 10 cycles"); end
    // A pixel arriving while flushed is queued but the flag holds.
    send_pixel(16'd77, 3'd3, 1, 3);
    n_cmp++; if (bus.frame_flushed !== 1'b1) begin
      n_fail++; $display("FAIL flush_hold got %b want 1", bus.frame_flushed); end
    bus.frame_done = 1'b0;
    @(negedge Clck);
    n_cmp++; if (bus.frame_flushed !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop got %b want 0", bus.frame_flushed); end
  endtask

  task automatic test_mid_reset;
    do_reset(2);
    bus.mem_ready = 1'b0;
    bus.frame_done = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send_pixel(ADDR_W'(500 + i), 3'd1, 1, 1);
    bus.mem_ready = 1'b1;
    repeat (9) @(negedge Clck);
    bus.mem_ready = 1'b0;
    n_cmp++; if (bus.level !== 5'd7 || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre got lvl=%0d ovf=%b want 7/1", bus.level, bus.overflow); end
    bus.mem_ready = 1'b1;
    do_reset(1);
    n_cmp++; if (bus.level !== 5'd0 || bus.mem_write !== 1'b0 || bus.overflow !== 1'b0 || bus.frame_flushed !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got lvl=%0d mw=%b ovf=%b fl=%b want 0/0/0/0",
                         bus.level, bus.mem_write, bus.overflow, bus.frame_flushed); end
    obs_log.delete();
    repeat (6) @(negedge Clck);
    n_cmp++; if (obs_log.size() != 0) begin
      n_fail++; $display("FAIL midrst_stale got %0d writes want 0", obs_log.size()); end
  endtask

  task automatic test_random;
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      bus.pix_print_enable = ($urandom_range(0, 2) != 0);
      bus.pix_address      = ADDR_W'($urandom);
      bus.pix_color        = COLOR_W'($urandom);
      if ((i % 150) < 70) bus.mem_ready = ($urandom_range(0, 5) == 0);
      else                bus.mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.frame_done = ~bus.frame_done;
      @(negedge Clck);
      n_cmp++; if (bus.mem_write !== m_mw || (m_mw && (bus.mem_address !== m_addr || bus.mem_color !== m_color))) begin
        n_fail++; $display("FAIL rand_write@%0d got %b %h/%0d want %b %h/%0d", i,
                           bus.mem_write, bus.mem_address, bus.mem_color, m_mw, m_addr, m_color); end
      n_cmp++; if (bus.level !== 5'(exp_q.size())) begin
        n_fail++; $display("FAIL rand_level@%0d got %0d want %0d", i, bus.level, exp_q.size()); end
      n_cmp++; if (bus.overflow !== m_overflow || bus.frame_flushed !== m_flushed) begin
        n_fail++; $display("FAIL rand_flags@%0d got ovf=%b fl=%b want %b/%b", i,
                           bus.overflow, bus.frame_flushed, m_overflow, m_flushed); end
    end
    bus.pix_print_enable = 1'b0;
    bus.frame_done       = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    Reset  = 1'b0;
    @(negedge Clck);
    test_reset;
    test_single_pixel;
    test_stall_order;
    test_overflow;
    test_full_simultaneous;
    test_frame_flush;
    test_mid_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
